// File: rtl/aes_mode_engine.sv
// Block-cipher chaining engine placed in front of a single-block AES core.
// Adds CBC and CTR chaining around an ECB-only core; one block in flight.
module aes_mode_engine #(
  parameter int DATA_W = 128,
  parameter int CTR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  // configuration
  input  logic              cfg_load,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_enc,
  input  logic [DATA_W-1:0] cfg_iv,
  // input block stream
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  // output block stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  // AES core request
  output logic              core_req_valid,
  input  logic              core_req_ready,
  output logic [DATA_W-1:0] core_req_data,
  output logic              core_req_enc,
  // AES core response
  input  logic              core_rsp_valid,
  input  logic [DATA_W-1:0] core_rsp_data,
  // status
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Reserved encoding 3 falls through to ECB handling everywhere.
  typedef enum logic [1:0] {
    M_ECB = 2'd0,
    M_CBC = 2'd1,
    M_CTR = 2'd2,
    M_RSV = 2'd3
  } mode_t;

  state_t state_q, state_d;

  mode_t             mode_q;
  logic              enc_q;
  logic [DATA_W-1:0] iv_q;
  logic [DATA_W-1:0] chain_q;
  logic [DATA_W-1:0] din_q;
  logic              last_q;

  logic [DATA_W-1:0] req_data_d;
  logic              req_enc_d;
  logic [DATA_W-1:0] rsp_out_d;
  logic [DATA_W-1:0] chain_rsp_d;
  logic [DATA_W-1:0] ctr_next;

  logic              in_fire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs decoded from state
  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    core_req_valid = 1'b0;
    out_valid      = 1'b0;
    busy           = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = ~cfg_load;
        if (in_valid && !cfg_load) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        core_req_valid = 1'b1;
        if (core_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_rsp_valid) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_fire = in_valid && in_ready;

  // Counter block successor: low CTR_W bits wrap, upper bits stay fixed
  assign ctr_next = {chain_q[DATA_W-1:CTR_W], chain_q[CTR_W-1:0] + CTR_W'(1)};

  // Core request built from the incoming block; chain_q cannot change
  // between acceptance and the core handshake, so forming it from in_data
  // at capture time equals forming it from din_q in REQ.
  always_comb begin
    req_data_d = in_data;
    req_enc_d  = enc_q;
    unique case (mode_q)
      M_CBC: begin
        if (enc_q) begin
          req_data_d = in_data ^ chain_q;
        end
      end
      M_CTR: begin
        req_data_d = chain_q;
        req_enc_d  = 1'b1;
      end
      default: begin
        req_data_d = in_data;
        req_enc_d  = enc_q;
      end
    endcase
  end

  // Post-processing of the core result and the chaining value update
  always_comb begin
    rsp_out_d   = core_rsp_data;
    chain_rsp_d = chain_q;
    unique case (mode_q)
      M_CBC: begin
        if (enc_q) begin
          chain_rsp_d = core_rsp_data;
        end else begin
          rsp_out_d   = core_rsp_data ^ chain_q;
          chain_rsp_d = din_q;
        end
      end
      M_CTR: begin
        rsp_out_d   = core_rsp_data ^ din_q;
        chain_rsp_d = ctr_next;
      end
      default: begin
        rsp_out_d   = core_rsp_data;
        chain_rsp_d = chain_q;
      end
    endcase
  end

  // Configuration, block capture, request/response registers and chaining
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= M_ECB;
      enc_q         <= 1'b1;
      iv_q          <= '0;
      chain_q       <= '0;
      din_q         <= '0;
      last_q        <= 1'b0;
      core_req_data <= '0;
      core_req_enc  <= 1'b1;
      out_data      <= '0;
      out_last      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cfg_load) begin
            mode_q  <= mode_t'(cfg_mode);
            enc_q   <= cfg_enc;
            iv_q    <= cfg_iv;
            chain_q <= cfg_iv;
          end else if (in_fire) begin
            din_q         <= in_data;
            last_q        <= in_last;
            core_req_data <= req_data_d;
            core_req_enc  <= req_enc_d;
          end
        end
        S_WAIT: begin
          if (core_rsp_valid) begin
            out_data <= rsp_out_d;
            out_last <= last_q;
            chain_q  <= chain_rsp_d;
          end
        end
        S_OUT: begin
          if (out_ready && last_q) begin
            chain_q <= iv_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mode_engine.sv
// Self-checking bench for aes_mode_engine: known-answer AES core model,
// abstract mode model with per-cycle comparison, plus literal vectors.
module tb_aes_mode_engine;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_load;
  logic [1:0]    cfg_mode;
  logic          cfg_enc;
  logic [DW-1:0] cfg_iv;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          core_req_valid;
  logic          core_req_ready;
  logic [DW-1:0] core_req_data;
  logic          core_req_enc;
  logic          core_rsp_valid;
  logic [DW-1:0] core_rsp_data;
  logic          busy;

  aes_mode_engine #(.DATA_W(DW), .CTR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_enc(cfg_enc), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_data(core_req_data), .core_req_enc(core_req_enc),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int core_lat  = 2;
  int req_stall = 0;
  int out_stall = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          flag;
  } ent_t;

  ent_t          req_q[$];
  ent_t          out_q[$];
  logic [DW-1:0] act_out[$];
  logic [DW-1:0] act_req[$];

  // abstract engine state
  logic [1:0]    m_mode;
  logic          m_enc;
  logic [DW-1:0] m_iv;
  logic [DW-1:0] m_chain;
  bit            inflight, req_done, rsp_got;

  // known-answer AES pairs
  logic [DW-1:0] kat_pt[$];
  logic [DW-1:0] kat_ct[$];
  logic [DW-1:0] vp[4], vcbc[4], vctr[4];

  localparam logic [DW-1:0] TOY_K = 128'h5a3c_96e1_0f1e_2d3c_4b5a_6978_8796_a5b4;
  localparam logic [DW-1:0] IV_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [DW-1:0] CTR0  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name, input logic [DW-1:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h required nothing", name, act);
  endtask

  // Single-block AES oracle: table of known pairs, invertible toy map otherwise
  function automatic logic [DW-1:0] aes_fn(input logic enc, input logic [DW-1:0] x);
    logic [DW-1:0] z;
    for (int i = 0; i < kat_pt.size(); i++) begin
      if (enc && kat_pt[i] == x) return kat_ct[i];
      if (!enc && kat_ct[i] == x) return kat_pt[i];
    end
    if (enc) begin
      return {x[DW-9:0], x[DW-1:DW-8]} ^ TOY_K;
    end
    z = x ^ TOY_K;
    return {z[7:0], z[DW-1:8]};
  endfunction

  // Mode semantics applied to one accepted block
  task automatic model_push(input logic [DW-1:0] d, input logic last);
    ent_t r, o;
    case (m_mode)
      2'd1: begin
        if (m_enc) begin
          r.data = d ^ m_chain; r.flag = 1'b1;
          o.data = aes_fn(1'b1, r.data);
          m_chain = o.data;
        end else begin
          r.data = d; r.flag = 1'b0;
          o.data = aes_fn(1'b0, d) ^ m_chain;
          m_chain = d;
        end
      end
      2'd2: begin
        r.data = m_chain; r.flag = 1'b1;
        o.data = aes_fn(1'b1, m_chain) ^ d;
        m_chain[31:0] = m_chain[31:0] + 32'd1;
      end
      default: begin
        r.data = d; r.flag = m_enc;
        o.data = aes_fn(m_enc, d);
      end
    endcase
    o.flag = last;
    if (last) m_chain = m_iv;
    req_q.push_back(r);
    out_q.push_back(o);
  endtask

  // Compare process: outputs checked against the model on every cycle
  initial begin
    bit was_idle;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_q.delete(); out_q.delete();
        m_mode = 2'd0; m_enc = 1'b1; m_iv = '0; m_chain = '0;
        inflight = 0; req_done = 0; rsp_got = 0;
      end else begin
        chk("busy", DW'(busy), DW'(inflight));
        chk("in_ready", DW'(in_ready), DW'(!inflight && !cfg_load));
        chk("core_req_valid", DW'(core_req_valid), DW'(inflight && !req_done));
        chk("out_valid", DW'(out_valid), DW'(inflight && rsp_got));
        if (core_req_valid) begin
          if (req_q.size() == 0) fail_note("req_unexpected", core_req_data);
          else begin
            chk("core_req_data", core_req_data, req_q[0].data);
            chk("core_req_enc", DW'(core_req_enc), DW'(req_q[0].flag));
          end
        end
        if (out_valid) begin
          if (out_q.size() == 0) fail_note("out_unexpected", out_data);
          else begin
            chk("out_data", out_data, out_q[0].data);
            chk("out_last", DW'(out_last), DW'(out_q[0].flag));
          end
        end
        was_idle = !inflight;
        if (core_req_valid && core_req_ready) begin
          req_done = 1;
          act_req.push_back(core_req_data);
          if (req_q.size() > 0) void'(req_q.pop_front());
        end
        if (core_rsp_valid && inflight && req_done) rsp_got = 1;
        if (out_valid && out_ready) begin
          act_out.push_back(out_data);
          if (out_q.size() > 0) void'(out_q.pop_front());
          inflight = 0;
        end
        if (was_idle && cfg_load) begin
          m_mode = cfg_mode; m_enc = cfg_enc; m_iv = cfg_iv; m_chain = cfg_iv;
        end else if (was_idle && in_valid) begin
          model_push(in_data, in_last);
          inflight = 1; req_done = 0; rsp_got = 0;
        end
      end
    end
  end

  // AES core model: optional request stall, fixed latency, 1-cycle response pulse
  initial begin
    logic [DW-1:0] d;
    logic          e;
    core_req_ready = 1'b1;
    core_rsp_valid = 1'b0;
    core_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (core_req_valid && req_stall > 0) begin
        core_req_ready = 1'b0;
        req_stall--;
      end else begin
        core_req_ready = 1'b1;
      end
      @(negedge clk);
      if (!rst && core_req_valid && core_req_ready) begin
        d = core_req_data;
        e = core_req_enc;
        @(posedge clk);
        repeat (core_lat - 1) @(posedge clk);
        #1;
        core_rsp_valid = 1'b1;
        core_rsp_data  = aes_fn(e, d);
        @(posedge clk); #1;
        core_rsp_valid = 1'b0;
        core_rsp_data  = '0;
      end
    end
  end

  // Output sink with optional backpressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (out_valid && out_stall > 0) begin
        out_ready = 1'b0;
        out_stall--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [1:0] mode, input logic enc, input logic [DW-1:0] iv);
    cfg_mode = mode; cfg_enc = enc; cfg_iv = iv; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (inflight && n < 400) begin
      step();
      n++;
    end
    if (inflight) fail_note("idle_timeout", DW'(n));
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last, input bit wait_done);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) fail_note("accept_timeout", d);
    step();
    in_valid = 1'b0;
    if (wait_done) wait_idle();
  endtask

  function automatic logic [DW-1:0] last_out();
    return (act_out.size() > 0) ? act_out[act_out.size()-1] : 'x;
  endfunction

  function automatic logic [DW-1:0] last_req();
    return (act_req.size() > 0) ? act_req[act_req.size()-1] : 'x;
  endfunction

  initial begin
    logic [DW-1:0] wiv;
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] prev, ctr;
    logic [DW-1:0] wiv;
    vp[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    vp[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    vp[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    vp[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    vcbc[0] = 128'h7649abac8119b246cee98e9b12e9197d;
    vcbc[1] = 128'h5086cb9b507219ee95db113a917678b2;
    vcbc[2] = 128'h73bed6b8e3c1743b7116e69e22229516;
    vcbc[3] = 128'h3ff1caa1681fac09120eca307586e1a7;
    vctr[0] = 128'h874d6191b620e3261bef6864990db6ce;
    vctr[1] = 128'h9806f66b7970fdff8617187bb9fffdff;
    vctr[2] = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
    vctr[3] = 128'h1e031dda2fbe03d1792170a0f3009cee;
    kat_pt.push_back(128'h00112233445566778899aabbccddeeff);
    kat_ct.push_back(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    for (int i = 0; i < 4; i++) begin
      prev = (i == 0) ? IV_A : vcbc[i-1];
      kat_pt.push_back(vp[i] ^ prev);
      kat_ct.push_back(vcbc[i]);
      ctr = CTR0;
      ctr[31:0] = ctr[31:0] + 32'(i);
      kat_pt.push_back(ctr);
      kat_ct.push_back(vp[i] ^ vctr[i]);
    end

    rst = 1'b1; cfg_load = 1'b0; cfg_mode = '0; cfg_enc = 1'b0; cfg_iv = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", DW'(out_last), '0);
    chk("rst_core_req_data", core_req_data, '0);
    chk("rst_in_ready", DW'(in_ready), DW'(1));
    chk("rst_busy", DW'(busy), '0);
    step();

    // ECB known answers, both directions
    cfg(2'd0, 1'b1, '0);
    send(128'h00112233445566778899aabbccddeeff, 1'b1, 1);
    chk("ecb_enc_kat", last_out(), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    cfg(2'd0, 1'b0, '0);
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 1);
    chk("ecb_dec_kat", last_out(), 128'h00112233445566778899aabbccddeeff);

    // CBC encrypt four blocks
    cfg(2'd1, 1'b1, IV_A);
    for (int i = 0; i < 4; i++) begin
      send(vp[i], i == 3, 1);
      if (i == 0) chk("cbc_first_req", last_req(), 128'h6bc0bce12a459991e134741a7f9e1925);
      chk("cbc_enc_kat", last_out(), vcbc[i]);
    end

    // CBC decrypt four blocks
    cfg(2'd1, 1'b0, IV_A);
    for (int i = 0; i < 4; i++) begin
      send(vcbc[i], i == 3, 1);
      chk("cbc_dec_kat", last_out(), vp[i]);
    end

    // CTR four blocks, then a new message restarting from the IV
    cfg(2'd2, 1'b0, CTR0);
    for (int i = 0; i < 4; i++) begin
      send(vp[i], i == 3, 1);
      chk("ctr_kat", last_out(), vctr[i]);
    end
    send(vp[0], 1'b1, 1);
    chk("ctr_restart_req", last_req(), CTR0);
    chk("ctr_restart_out", last_out(), vctr[0]);

    // CTR low-word wrap keeps upper bits
    wiv = {96'h0123456789abcdef01234567, 32'hffffffff};
    cfg(2'd2, 1'b1, wiv);
    send(128'h11112222333344445555666677778888, 1'b0, 1);
    send(128'h9999aaaabbbbccccddddeeeeffff0000, 1'b1, 1);
    chk("ctr_wrap_req", last_req(), {96'h0123456789abcdef01234567, 32'h00000000});
    send(128'h0, 1'b1, 1);
    chk("ctr_wrap_restart", last_req(), wiv);

    // Reserved mode behaves as ECB
    cfg(2'd3, 1'b1, 128'hdeadbeef);
    send(128'h00112233445566778899aabbccddeeff, 1'b1, 1);
    chk("rsv_as_ecb", last_out(), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Backpressure on both sides with a second block waiting at the input
    cfg(2'd1, 1'b1, IV_A);
    req_stall = 3; out_stall = 5; core_lat = 3;
    send(vp[0], 1'b0, 0);
    send(vp[1], 1'b1, 1);
    chk("bp_cbc_out", last_out(), vcbc[1]);
    core_lat = 2;

    // cfg_load while a block is in flight is ignored
    cfg(2'd1, 1'b1, IV_A);
    req_stall = 3;
    send(vp[0], 1'b0, 0);
    cfg(2'd2, 1'b0, 128'h5555);
    wait_idle();
    send(vp[1], 1'b1, 1);
    chk("cfg_in_req_ignored", last_out(), vcbc[1]);

    // Reset while waiting on the core
    core_lat = 6;
    cfg(2'd1, 1'b1, IV_A);
    send(vp[0], 1'b0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_out_valid", DW'(out_valid), '0);
    chk("rstw_core_req_valid", DW'(core_req_valid), '0);
    chk("rstw_busy", DW'(busy), '0);
    chk("rstw_in_ready", DW'(in_ready), DW'(1));
    step();
    repeat (10) step();
    core_lat = 2;
    send(128'h00112233445566778899aabbccddeeff, 1'b1, 1);
    chk("post_rst_ecb", last_out(), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
